// File: rtl/decoder_proj_formal_core.sv
// Registered hex-to-seven-segment decoder with a dp flag for codes A-F.
// Define DECODER_PROJ_FORMAL_EN to compile in the embedded formal properties.
module decoder_proj_formal_core #(
   parameter logic SEG_ACTIVE_LOW = 1'b0
) (
   input  logic [6:0] io_in,
   output logic [7:0] io_out,
   output logic [7:0] io_oeb
);

   logic       clk;
   logic       rst_s;
   logic       en_s;
   logic [3:0] code_s;
   logic [7:0] r_q;
   logic [7:0] r_d;

   assign clk    = io_in[0];
   assign rst_s  = io_in[1];
   assign en_s   = io_in[2];
   assign code_s = io_in[6:3];

   // Segment pattern in gfedcba order for one hex digit.
   function automatic logic [6:0] seg_decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         4'hF:    seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   // Next display value: load a decoded digit when enabled, otherwise hold.
   always_comb begin
      r_d = r_q;
      if (en_s) begin
         r_d = {(code_s >= 4'hA), seg_decode(code_s)};
      end else begin
         r_d = r_q;
      end
   end

   // Display register; reset wins over any concurrent load.
   always_ff @(posedge clk) begin
      if (rst_s) begin
         r_q <= 8'h00;
      end else begin
         r_q <= r_d;
      end
   end

   assign io_out = SEG_ACTIVE_LOW ? ~r_q : r_q;
   assign io_oeb = 8'h00;

`ifdef DECODER_PROJ_FORMAL_EN
   logic f_past_valid_q = 1'b0;

   // Marks every cycle after the first so the initial-reset assumption applies once.
   always_ff @(posedge clk) begin
      f_past_valid_q <= 1'b1;
   end

   f_init_reset: assume property (@(posedge clk) !f_past_valid_q |-> rst_s);

   f_reset_blank: assert property (@(posedge clk) rst_s |=> (r_q == 8'h00));

   f_load: assert property (@(posedge clk) (en_s && !rst_s) |=>
      (r_q == {($past(code_s) >= 4'hA), seg_decode($past(code_s))}));

   f_hold: assert property (@(posedge clk) (!en_s && !rst_s) |=> (r_q == $past(r_q)));

   f_oeb_zero: assert property (@(posedge clk) (io_oeb == 8'h00));

   // Bit 0 is the clock itself, so only the upper six input bits are matched.
   f_cov_rst_msb: cover property (@(posedge clk) (io_in[6:1] == 6'b100001));

   for (genvar g = 0; g < 16; g++) begin : g_cov_code
      f_cov_load: cover property (@(posedge clk) (en_s && !rst_s && (code_s == 4'(g))));
   end
`endif

endmodule

// File: tb/tb_decoder_proj_formal_core.sv
// Randomized and directed bench for decoder_proj_formal_core, both output polarities.
module tb_decoder_proj_formal_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] code = 4'h0;
   logic [6:0] io_in;
   logic [7:0] out_hi, oeb_hi, out_lo, oeb_lo;
   logic [7:0] exp_r;
   int         vectors = 0;
   int         miscompares = 0;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   assign io_in = {code, en, rst, clk};

   always #5 clk = ~clk;

   decoder_proj_formal_core #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
      .io_in (io_in),
      .io_out(out_hi),
      .io_oeb(oeb_hi)
   );

   decoder_proj_formal_core #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
      .io_in (io_in),
      .io_out(out_lo),
      .io_oeb(oeb_lo)
   );

   task automatic drive(input logic r, input logic e, input logic [3:0] c);
      @(negedge clk);
      rst  = r;
      en   = e;
      code = c;
   endtask

   // Advance one edge, updating the reference from the values seen at that edge.
   task automatic tick;
      @(posedge clk);
      if (rst)
         exp_r = 8'h00;
      else if (en)
         exp_r = {(int'(code) >= 10) ? 1'b1 : 1'b0, seg_tab[code]};
      #1;
   endtask

   task automatic test_reset;
      drive(1'b1, 1'b0, 4'h8);
      tick();
      vectors++;
      if (out_hi !== 8'h00) begin
         $display("FAIL reset_out: got %h want 00", out_hi); miscompares++;
      end
      vectors++;
      if (oeb_hi !== 8'h00) begin
         $display("FAIL reset_oeb: got %h want 00", oeb_hi); miscompares++;
      end
      vectors++;
      if (out_lo !== 8'hFF) begin
         $display("FAIL reset_out_lo: got %h want FF", out_lo); miscompares++;
      end
      vectors++;
      if (oeb_lo !== 8'h00) begin
         $display("FAIL reset_oeb_lo: got %h want 00", oeb_lo); miscompares++;
      end
   endtask

   task automatic test_load_three;
      drive(1'b0, 1'b1, 4'h3);
      tick();
      vectors++;
      if (out_hi !== 8'h4F) begin
         $display("FAIL load_3: got %h want 4F", out_hi); miscompares++;
      end
   endtask

   task automatic test_hold;
      drive(1'b0, 1'b1, 4'hA);
      tick();
      vectors++;
      if (out_hi !== 8'hF7) begin
         $display("FAIL load_A: got %h want F7", out_hi); miscompares++;
      end
      drive(1'b0, 1'b0, 4'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (out_hi !== 8'hF7) begin
            $display("FAIL hold_A cyc%0d: got %h want F7", i, out_hi); miscompares++;
         end
      end
   endtask

   task automatic test_reset_priority;
      drive(1'b1, 1'b1, 4'h8);
      tick();
      vectors++;
      if (out_hi !== 8'h00) begin
         $display("FAIL rst_vs_en: got %h want 00", out_hi); miscompares++;
      end
   endtask

   task automatic test_active_low;
      drive(1'b1, 1'b0, 4'h0);
      tick();
      vectors++;
      if (out_lo !== 8'hFF) begin
         $display("FAIL al_reset: got %h want FF", out_lo); miscompares++;
      end
      drive(1'b0, 1'b1, 4'h0);
      tick();
      vectors++;
      if (out_lo !== 8'hC0) begin
         $display("FAIL al_code0: got %h want C0", out_lo); miscompares++;
      end
   endtask

   // Each code must not appear before its edge and must appear right after it.
   task automatic test_sweep;
      for (int c = 0; c < 16; c++) begin
         drive(1'b0, 1'b1, 4'(c));
         #1;
         vectors++;
         if (out_hi !== exp_r) begin
            $display("FAIL sweep_early code%0d: got %h want %h", c, out_hi, exp_r); miscompares++;
         end
         tick();
         vectors++;
         if (out_hi !== {(c >= 10) ? 1'b1 : 1'b0, seg_tab[c]}) begin
            $display("FAIL sweep code%0d: got %h want %h", c, out_hi, {(c >= 10) ? 1'b1 : 1'b0, seg_tab[c]});
            miscompares++;
         end
         vectors++;
         if (out_lo !== ~exp_r) begin
            $display("FAIL sweep_lo code%0d: got %h want %h", c, out_lo, ~exp_r); miscompares++;
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0,
               4'($urandom_range(0, 15)));
         tick();
         vectors++;
         if (out_hi !== exp_r) begin
            $display("FAIL rand%0d: got %h want %h", i, out_hi, exp_r); miscompares++;
         end
         vectors++;
         if (out_lo !== ~exp_r || oeb_hi !== 8'h00) begin
            $display("FAIL rand_lo%0d: got %h/%h want %h/00", i, out_lo, oeb_hi, ~exp_r); miscompares++;
         end
      end
   endtask

   initial begin
      exp_r = 8'h00;
      test_reset();
      test_load_three();
      test_hold();
      test_reset_priority();
      test_active_low();
      test_sweep();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
